// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory while holding the CPU in reset.
// One write strobe per 4 accepted bytes; byte_ready drops during WRITE and in the terminal DONE/ERR states.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR} state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  lane;
    logic [31:0] word;
    logic [7:0]  chk;
    logic [15:0] len_rx;
    logic        accept;

    assign len_rx = {byte_data, len[7:0]};
    assign accept = byte_valid & byte_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LEN0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            LEN0: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = LEN1;
            end
            LEN1: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if ({1'b0, len_rx} > MAX_N)  state_nxt = ERR;
                    else if (len_rx == 16'd0)    state_nxt = CHK;
                    else                         state_nxt = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && lane == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                imem_we   = 1'b1;
                state_nxt = (idx + 16'd1 == len) ? CHK : DATA;
            end
            CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = (byte_data == chk) ? DONE : ERR;
            end
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERR: begin
                err = 1'b1;
            end
            default: state_nxt = LEN0;
        endcase
    end

    // Address/data are registered on the 4th byte so they are stable for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len        <= '0;
            idx        <= '0;
            lane       <= '0;
            word       <= '0;
            chk        <= '0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
        end else begin
            case (state)
                LEN0: if (accept) begin
                    len[7:0] <= byte_data;
                    chk      <= chk ^ byte_data;
                end
                LEN1: if (accept) begin
                    len[15:8] <= byte_data;
                    chk       <= chk ^ byte_data;
                end
                DATA: if (accept) begin
                    chk                      <= chk ^ byte_data;
                    lane                     <= lane + 2'd1;
                    word[{lane, 3'b000} +: 8] <= byte_data;
                    if (lane == 2'd3) begin
                        imem_wdata <= {byte_data, word[23:0]};
                        imem_addr  <= BASE_ADDR + {14'd0, idx, 2'b00};
                    end
                end
                WRITE: begin
                    idx  <= idx + 16'd1;
                    word <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as images are sent and popped by the write monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          errors = 0;
    int          checks = 0;
    int          writes_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_t w;
            writes_seen++;
            check("wr_rdy", 32'(byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexp_we", 32'(imem_we), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", imem_addr, w.addr);
                check("wr_data", imem_wdata, w.data);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int n;
        if (toggle) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Sends img as a full stream; corrupt is XORed into the checksum byte.
    task automatic send_image(input bit toggle, input logic [7:0] corrupt);
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        wr_t         e;
        n = 16'(img.size());
        x = n[7:0] ^ n[15:8];
        send_byte(n[7:0], toggle);
        send_byte(n[15:8], toggle);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            e.addr = 32'(i) * 4;
            e.data = w;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                x = x ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], toggle);
            end
        end
        send_byte(x ^ corrupt, toggle);
    endtask

    initial begin
        int w0;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",    32'(imem_we),   32'd0);
        check("rst_addr",  imem_addr,      32'h0);
        check("rst_wdata", imem_wdata,     32'h0);
        check("rst_cpu",   32'(cpu_reset), 32'd1);
        check("rst_done",  32'(done),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(byte_ready), 32'd1);

        // Single-word image, stream 01 00 13 05 50 00 47.
        img = '{32'h0050_0513};
        w0 = writes_seen;
        send_image(1'b0, 8'h00);
        @(negedge clk);
        check("one_writes", 32'(writes_seen - w0), 32'd1);
        check("one_done",   32'(done),      32'd1);
        check("one_cpu",    32'(cpu_reset), 32'd0);
        check("one_err",    32'(err),       32'd0);
        check("one_hold",   imem_wdata,     32'h0050_0513);

        // Empty image, stream 00 00 00.
        do_reset();
        img = {};
        w0 = writes_seen;
        send_image(1'b0, 8'h00);
        @(negedge clk);
        check("zero_writes", 32'(writes_seen - w0), 32'd0);
        check("zero_done",   32'(done), 32'd1);

        // Two words with valid toggling every cycle.
        do_reset();
        img = '{32'h1122_3344, 32'hAABB_CCDD};
        w0 = writes_seen;
        send_image(1'b1, 8'h00);
        @(negedge clk);
        check("two_writes", 32'(writes_seen - w0), 32'd2);
        check("two_done",   32'(done), 32'd1);
        check("two_addr",   imem_addr, 32'h4);

        // Bad checksum 48 instead of 47.
        do_reset();
        img = '{32'h0050_0513};
        w0 = writes_seen;
        send_image(1'b0, 8'h0F);
        @(negedge clk);
        check("bad_err",   32'(err),        32'd1);
        check("bad_done",  32'(done),       32'd0);
        check("bad_cpu",   32'(cpu_reset),  32'd1);
        check("bad_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            byte_data = 8'(i * 37);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check("bad_writes", 32'(writes_seen - w0), 32'd1);
        check("bad_stick",  32'(err), 32'd1);

        // Oversized length 0x41 > 64.
        do_reset();
        w0 = writes_seen;
        send_byte(8'h41, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        check("big_err",    32'(err), 32'd1);
        check("big_writes", 32'(writes_seen - w0), 32'd0);

        // Reset after two data bytes, then a clean image.
        do_reset();
        w0 = writes_seen;
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h05, 1'b0);
        do_reset();
        img = '{32'h0050_0513};
        send_image(1'b0, 8'h00);
        @(negedge clk);
        check("mid_writes", 32'(writes_seen - w0), 32'd1);
        check("mid_done",   32'(done), 32'd1);

        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
